bg_parallax: RTL and testbench
==============================

Name: bg_parallax

Overview:
Parametrised successor to the single-speed background renderer for the runner game's VGA path. It draws a scrolling ground line with a mound, scrolling ground speckle dots, NUM_CLOUDS parallax clouds and a hashed, twinkling star field. All frame state runs in the pixel clock domain; vsync is sampled, never used as a clock. The RGB output is registered and feeds the sprite mixer ahead of the VGA pins.

Parameters:
H_RES, 1024, active horizontal pixels; also the scroll wrap modulus.
GROUND_Y, 628, row of the flat ground line.
NUM_CLOUDS, 4, number of cloud instances (1..8).
CLOUD_SHIFT, 1, the cloud layer scrolls at ground speed >> CLOUD_SHIFT.
TWINKLE_DIV, 8, frames per star-twinkle phase (power of 2, 2..64).

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
video_active  in  1  1 = pix_x/pix_y is a visible pixel
pix_x  in  10  current column
pix_y  in  10  current row
vsync  in  1  raw vertical sync, active high, asynchronous to the logic
speed  in  4  ground scroll in pixels per frame; 0 = stationary
pause  in  1  freeze all scroll and twinkle state
R, G, B  out  2 each  pixel colour
frame_tick  out  1  one-cycle pulse per vsync rising edge
scroll_pos  out  10  current ground scroll offset, 0..H_RES-1

Behaviour:
- Reset is asynchronous, active-low (rst_n). It clears all registers: scroll_pos=0, cloud_acc=0, twinkle counter and phase=0, frame_tick=0, R/G/B=0, pipeline valid=0.
- vsync path: 2-FF synchroniser, then a rising-edge detect. frame_tick is high for exactly 1 clk, 3 clks after vsync rises. A vsync that stays high produces only one tick.
- On frame_tick with pause=0, speed is sampled at the tick:
  - scroll_pos <= scroll_pos+speed; subtract H_RES if the sum >= H_RES. The wrap must be exact: 1020+7 gives 3.
  - cloud_acc (10b) <= (cloud_acc+speed) mod H_RES; cloud_off = cloud_acc>>CLOUD_SHIFT.
  - twinkle counter increments; phase toggles when it wraps at TWINKLE_DIV-1.
- pause=1 coincident with frame_tick: all frame state holds. frame_tick itself still pulses.
- Ground: gx = (pix_x+scroll_pos) mod H_RES; mx = (gx-306) mod H_RES.
  - If mx<64: idx = mx<32 ? mx : 63-mx, and height comes from the LUT idx 0-5:0, 6-8:1, 9-12:2, 13-15:3, 16-18:4, 19-21:5, else 6.
  - Otherwise height=0. gy = GROUND_Y-height.
  - Ground line: pix_y==gy.
  - Dots: pix_y==gy+3 when gx mod 8==2; pix_y==gy+5 when gx mod 11==4; pix_y==gy+7 when gx mod 17==9. True modulo over the full gx range.
- Cloud i (0..NUM_CLOUDS-1):
  - cx = (140+i*(H_RES/NUM_CLOUDS)+H_RES-cloud_off) mod H_RES; cy = GROUND_Y-156+20*(i mod 2).
  - Bitmap is 20x8 at scale 2. Rows MSB-first: 01E00,07F00,1FF80,3FFC0,7FFE0,3FFC0,1FF80,07F00.
  - A cloud is not drawn across the right-edge wrap; it is clipped.
- Stars: only for rows GROUND_Y-190 <= pix_y < GROUND_Y-100.
  - h = pix_x ^ {pix_y[4:0],pix_y[9:5]}; a star needs h[5:0]==6'h2A.
  - phase=0: show only stars with h[6]=0. phase=1: show all.
- Pipeline: stage 1 registers the layer hit flags and video_active; stage 2 registers the colour. RGB corresponds to the pix_x/pix_y presented 2 clks earlier.
- Colour priority: video_active=0 gives 00/00/00. Then ground line 11/11/11 > dots 10/10/10 > cloud 11/11/11 > star 11/11/11 > sky 00/00/00.
- Scroll state changes only on frame_tick, so values are stable across every visible line.
- Reset mid-frame: outputs go to 0 immediately. Drawing resumes correctly within 2 clks of rst_n release, with scroll at 0.

Optional Feature:
BG_DAY_NIGHT_EN:
- When defined: adds input day (1b), sampled on frame_tick.
  - Day: sky = 01/10/11, stars suppressed, clouds 11/11/11, ground and dots 01/01/00.
  - Night: colours as above.
- When undefined: no port, night palette only.

Test Plan:
- Reset then speed=5, pause=0, 10 vsync pulses -> scroll_pos=50, exactly 10 frame_tick pulses, each 3 clks after its vsync rise.
- scroll_pos=1020 (reached via preload speed sequence), speed=7, one tick -> scroll_pos=3; ground line drawn continuously at columns 1023->0.
- pause=1 held over 4 vsyncs with speed=9 -> scroll_pos, cloud offset and twinkle phase unchanged; frame_tick still pulses 4 times.
- scroll_pos=0, pixel (306+31, GROUND_Y-6) active -> RGB=11/11/11 two clks later; same pixel with video_active=0 -> 00/00/00.
- TWINKLE_DIV=8, 8 ticks -> phase 0->1; pixel with h[5:0]=2A, h[6]=1 in the star band shows 00 in phase 0 and 11 in phase 1.
- Async reset asserted mid-line -> RGB, frame_tick and scroll_pos are 0 in the same cycle; after release the first valid RGB appears on the 2nd clk.

Source files
------------

// File: rtl/bg_parallax.sv
// bg_parallax: scrolling ground with mound and speckle dots, parallax clouds and
// a hashed twinkling star field for the runner game's VGA path.
// Frame state advances once per vsync rising edge, detected in the pixel clock
// domain. RGB is registered two pixel clocks after pix_x/pix_y are presented.
// Optional build macro: BG_DAY_NIGHT_EN adds a 'day' input and a day palette.
module bg_parallax #(
  parameter int H_RES       = 1024,
  parameter int GROUND_Y    = 628,
  parameter int NUM_CLOUDS  = 4,
  parameter int CLOUD_SHIFT = 1,
  parameter int TWINKLE_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       video_active,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       vsync,
  input  logic [3:0] speed,
  input  logic       pause,
`ifdef BG_DAY_NIGHT_EN
  input  logic       day,
`endif
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B,
  output logic       frame_tick,
  output logic [9:0] scroll_pos
);

  localparam int TW_W = $clog2(TWINKLE_DIV);
  localparam logic [TW_W-1:0] TW_LAST = TW_W'(TWINKLE_DIV - 1);

  logic            vs_meta, vs_sync, vs_prev;
  logic [9:0]      cloud_acc, cloud_off;
  logic [TW_W-1:0] tw_cnt;
  logic            phase;
  logic [10:0]     scroll_sum, cloud_sum;
  logic [9:0]      scroll_next, cloud_next;

  logic [10:0]     gx_sum;
  logic [9:0]      gx, mx, gy;
  logic [5:0]      idx;
  logic [2:0]      height;
  logic            ground_hit, dot_hit, cloud_hit, star_hit;
  logic [6:0]      hash_lo;

  logic            s1_active, s1_ground, s1_dot, s1_cloud, s1_star;
  logic [5:0]      rgb_next;

`ifdef BG_DAY_NIGHT_EN
  logic            day_q;
`endif

  // Cloud bitmap, 20 columns wide, MSB is the leftmost column.
  function automatic logic [19:0] cloud_row(input logic [2:0] r);
    case (r)
      3'd0:    cloud_row = 20'h01E00;
      3'd1:    cloud_row = 20'h07F00;
      3'd2:    cloud_row = 20'h1FF80;
      3'd3:    cloud_row = 20'h3FFC0;
      3'd4:    cloud_row = 20'h7FFE0;
      3'd5:    cloud_row = 20'h3FFC0;
      3'd6:    cloud_row = 20'h1FF80;
      default: cloud_row = 20'h07F00;
    endcase
  endfunction

  // Synchronise raw vsync and turn its rising edge into a one-clock frame_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= vsync;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_tick <= vs_sync & ~vs_prev;
    end
  end

  // Next scroll and cloud accumulator values, wrapped exactly at H_RES.
  always_comb begin
    scroll_sum  = {1'b0, scroll_pos} + {7'd0, speed};
    cloud_sum   = {1'b0, cloud_acc} + {7'd0, speed};
    scroll_next = (scroll_sum >= 11'(H_RES)) ? 10'(scroll_sum - 11'(H_RES)) : scroll_sum[9:0];
    cloud_next  = (cloud_sum >= 11'(H_RES)) ? 10'(cloud_sum - 11'(H_RES)) : cloud_sum[9:0];
  end

  // Frame state advances only on frame_tick, and pause freezes all of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_pos <= '0;
      cloud_acc  <= '0;
      tw_cnt     <= '0;
      phase      <= 1'b0;
    end else if (frame_tick && !pause) begin
      scroll_pos <= scroll_next;
      cloud_acc  <= cloud_next;
      if (tw_cnt == TW_LAST) begin
        tw_cnt <= '0;
        phase  <= ~phase;
      end else begin
        tw_cnt <= tw_cnt + TW_W'(1);
      end
    end
  end

`ifdef BG_DAY_NIGHT_EN
  // Day/night mode is latched once per frame so it never changes mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) day_q <= 1'b0;
    else if (frame_tick) day_q <= day;
  end
`endif

  assign cloud_off = cloud_acc >> CLOUD_SHIFT;

  // Ground line height from the mound profile, plus the three speckle dot rows.
  always_comb begin
    gx_sum = {1'b0, pix_x} + {1'b0, scroll_pos};
    gx     = (gx_sum >= 11'(H_RES)) ? 10'(gx_sum - 11'(H_RES)) : gx_sum[9:0];
    if (gx >= 10'd306) mx = gx - 10'd306;
    else               mx = 10'(11'(gx) + 11'(H_RES) - 11'd306);
    idx    = '0;
    height = '0;
    if (mx < 10'd64) begin
      idx = (mx < 10'd32) ? mx[5:0] : 6'd63 - mx[5:0];
      if      (idx <= 6'd5)  height = 3'd0;
      else if (idx <= 6'd8)  height = 3'd1;
      else if (idx <= 6'd12) height = 3'd2;
      else if (idx <= 6'd15) height = 3'd3;
      else if (idx <= 6'd18) height = 3'd4;
      else if (idx <= 6'd21) height = 3'd5;
      else                   height = 3'd6;
    end
    gy         = 10'(GROUND_Y) - {7'd0, height};
    ground_hit = (pix_y == gy);
    dot_hit    = ((pix_y == gy + 10'd3) && (gx[2:0] == 3'd2)) ||
                 ((pix_y == gy + 10'd5) && (gx % 10'd11 == 10'd4)) ||
                 ((pix_y == gy + 10'd7) && (gx % 10'd17 == 10'd9));
  end

  // Any cloud covering the pixel; clouds are clipped rather than wrapped at the right edge.
  always_comb begin
    int cx, cy, dx, dy;
    logic [19:0] row;
    logic [4:0]  col;
    cloud_hit = 1'b0;
    cx  = 0;
    cy  = 0;
    dx  = 0;
    dy  = 0;
    row = '0;
    col = '0;
    for (int i = 0; i < NUM_CLOUDS; i++) begin
      cx = (140 + i * (H_RES / NUM_CLOUDS) + H_RES - int'(cloud_off)) % H_RES;
      cy = GROUND_Y - 156 + 20 * (i % 2);
      dx = int'(pix_x) - cx;
      dy = int'(pix_y) - cy;
      if (dx >= 0 && dx < 40 && dy >= 0 && dy < 16) begin
        row = cloud_row(3'(dy / 2));
        col = 5'(dx / 2);
        if (row[5'd19 - col]) cloud_hit = 1'b1;
      end
    end
  end

  // Star hash only needs its low seven bits: match on [5:0], twinkle select on [6].
  always_comb begin
    hash_lo  = pix_x[6:0] ^ {pix_y[1:0], pix_y[9:5]};
    star_hit = (pix_y >= 10'(GROUND_Y - 190)) && (pix_y < 10'(GROUND_Y - 100)) &&
               (hash_lo[5:0] == 6'h2A) && (phase || !hash_lo[6]);
  end

  // Stage 1: register the layer hit flags alongside video_active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_active <= 1'b0;
      s1_ground <= 1'b0;
      s1_dot    <= 1'b0;
      s1_cloud  <= 1'b0;
      s1_star   <= 1'b0;
    end else begin
      s1_active <= video_active;
      s1_ground <= ground_hit;
      s1_dot    <= dot_hit;
      s1_cloud  <= cloud_hit;
      s1_star   <= star_hit;
    end
  end

  // Resolve layer priority into a colour, packed as {R,G,B}.
  always_comb begin
    rgb_next = 6'b000000;
`ifdef BG_DAY_NIGHT_EN
    if (!s1_active)                rgb_next = 6'b000000;
    else if (day_q) begin
      if (s1_ground || s1_dot)     rgb_next = 6'b010100;
      else if (s1_cloud)           rgb_next = 6'b111111;
      else                         rgb_next = 6'b011011;
    end
    else if (s1_ground)            rgb_next = 6'b111111;
    else if (s1_dot)               rgb_next = 6'b101010;
    else if (s1_cloud || s1_star)  rgb_next = 6'b111111;
`else
    if (!s1_active)                rgb_next = 6'b000000;
    else if (s1_ground)            rgb_next = 6'b111111;
    else if (s1_dot)               rgb_next = 6'b101010;
    else if (s1_cloud || s1_star)  rgb_next = 6'b111111;
`endif
  end

  // Stage 2: registered colour output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R <= 2'b00;
      G <= 2'b00;
      B <= 2'b00;
    end else begin
      R <= rgb_next[5:4];
      G <= rgb_next[3:2];
      B <= rgb_next[1:0];
    end
  end

endmodule

// File: tb/tb_bg_parallax.sv
// tb_bg_parallax: directed test of bg_parallax with hand-computed expectations.
module tb_bg_parallax;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       video_active;
  logic [9:0] pix_x, pix_y;
  logic       vsync;
  logic [3:0] speed;
  logic       pause;
  logic [1:0] R, G, B;
  logic       frame_tick;
  logic [9:0] scroll_pos;
`ifdef BG_DAY_NIGHT_EN
  logic       day = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int tick_count = 0;
  int unpaused_ticks = 0;
  int t0;

  bg_parallax dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .video_active (video_active),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .vsync        (vsync),
    .speed        (speed),
    .pause        (pause),
`ifdef BG_DAY_NIGHT_EN
    .day          (day),
`endif
    .R            (R),
    .G            (G),
    .B            (B),
    .frame_tick   (frame_tick),
    .scroll_pos   (scroll_pos)
  );

  always #5 clk = ~clk;

  // Count frame_tick pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && frame_tick) tick_count++;
  end

  // Safety net so the run always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one pixel and wait until its registered colour is on the outputs.
  task automatic applyStimulus(input int x, input int y, input logic act);
    @(posedge clk); #1;
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    video_active = act;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_pixel(input string tag, input int x, input int y,
                             input logic act, input int expected);
    applyStimulus(x, y, act);
    checkOutput(tag, int'({R, G, B}), expected);
  endtask

  // One vsync pulse: checks tick latency (3 clks) and optionally the pulse width.
  task automatic vsync_pulse(input string tag, input logic check_width);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    vsync = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (frame_tick) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, "_latency"}, lat, 3);
    @(posedge clk); #1;
    if (check_width) checkOutput({tag, "_width"}, int'(frame_tick), 0);
    repeat (3) @(posedge clk);
    #1;
    vsync = 1'b0;
    if (!pause) unpaused_ticks++;
    repeat (6) @(posedge clk);
  endtask

  function automatic int star_expect();
    return (((unpaused_ticks / 8) % 2) == 1) ? 63 : 0;
  endfunction

  initial begin
    rst_n        = 1'b0;
    vsync        = 1'b0;
    pause        = 1'b0;
    speed        = 4'd0;
    video_active = 1'b0;
    pix_x        = '0;
    pix_y        = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rgb", int'({R, G, B}), 0);
    checkOutput("reset_tick", int'(frame_tick), 0);
    checkOutput("reset_scroll", int'(scroll_pos), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] static scene at scroll 0");
    check_pixel("mound_peak", 337, 622, 1'b1, 63);
    check_pixel("mound_inactive", 337, 622, 1'b0, 0);
    check_pixel("below_mound", 337, 628, 1'b1, 0);
    check_pixel("mound_slope", 316, 626, 1'b1, 63);
    check_pixel("slope_flat_row", 316, 628, 1'b1, 0);
    check_pixel("flat_ground", 500, 628, 1'b1, 63);
    check_pixel("dot_mod8", 10, 631, 1'b1, 42);
    check_pixel("dot_mod11", 15, 633, 1'b1, 42);
    check_pixel("dot_mod17", 9, 635, 1'b1, 42);
    check_pixel("cloud_on", 154, 472, 1'b1, 63);
    check_pixel("cloud_off", 152, 472, 1'b1, 0);
    check_pixel("star_h6_0", 39, 440, 1'b1, 63);
    check_pixel("star_h6_1_ph0", 103, 440, 1'b1, 0);

    $display("[TB] speed 5 for 10 frames");
    speed = 4'd5;
    t0 = tick_count;
    for (int p = 1; p <= 10; p++) begin
      vsync_pulse("spd5", 1'b1);
      if (p == 7) check_pixel("twinkle_after7", 103, 440, 1'b1, 0);
      if (p == 8) check_pixel("twinkle_after8", 103, 440, 1'b1, 63);
    end
    checkOutput("scroll_50", int'(scroll_pos), 50);
    checkOutput("ticks_10", tick_count - t0, 10);

    $display("[TB] preload to 1020 then wrap");
    speed = 4'd15;
    for (int p = 0; p < 64; p++) vsync_pulse("pre15", 1'b0);
    speed = 4'd10;
    vsync_pulse("pre10", 1'b0);
    checkOutput("scroll_1020", int'(scroll_pos), 1020);
    check_pixel("ground_gx1023_pre", 3, 628, 1'b1, 63);
    check_pixel("ground_gx0_pre", 4, 628, 1'b1, 63);
    speed = 4'd7;
    vsync_pulse("wrap7", 1'b0);
    checkOutput("scroll_wrap_3", int'(scroll_pos), 3);
    check_pixel("ground_gx1023", 1020, 628, 1'b1, 63);
    check_pixel("ground_gx0", 1021, 628, 1'b1, 63);
    check_pixel("cloud_shift_on", 153, 472, 1'b1, 63);
    check_pixel("cloud_shift_off", 152, 472, 1'b1, 0);
    check_pixel("star_phase_model", 103, 440, 1'b1, star_expect());

    $display("[TB] pause over 4 frames");
    pause = 1'b1;
    speed = 4'd9;
    t0 = tick_count;
    for (int p = 0; p < 4; p++) vsync_pulse("pause", 1'b0);
    checkOutput("pause_scroll", int'(scroll_pos), 3);
    checkOutput("pause_ticks_4", tick_count - t0, 4);
    check_pixel("pause_cloud_on", 153, 472, 1'b1, 63);
    check_pixel("pause_cloud_off", 152, 472, 1'b1, 0);
    check_pixel("pause_star", 103, 440, 1'b1, star_expect());
    pause = 1'b0;

    $display("[TB] asynchronous reset mid-line");
    check_pixel("pre_reset_star", 39, 440, 1'b1, 63);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rgb", int'({R, G, B}), 0);
    checkOutput("async_tick", int'(frame_tick), 0);
    checkOutput("async_scroll", int'(scroll_pos), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_clk1", int'({R, G, B}), 0);
    @(posedge clk); #1;
    checkOutput("release_clk2", int'({R, G, B}), 63);
    check_pixel("post_reset_mound", 337, 622, 1'b1, 63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
